// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex UART with oversampled RX, TX/RX FIFOs and CTS/RTS
//   i_clk, i_rst            clock, synchronous active-high reset
//   o_baud_clk              oversample tick strobe (one i_clk cycle every Div cycles)
//   i_ctrl                  reserved, ignored
//   o_status                {rx_busy, tx_busy, framing_err, rx_overrun, rx_empty, rx_full, tx_empty, tx_full}
//   i_tx_data/i_tx_req/o_tx_rdy   TX FIFO write side
//   o_rx_data/i_rx_req/o_rx_rdy   RX FIFO read side, first-word fall-through
//   i_rx, o_tx              serial line
//   i_cts, o_rts            flow control
`timescale 1ns/1ps

module uart_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_rd,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_full  = (r_count == CntFull);
  assign o_empty = (r_count == '0);
  assign w_do_wr = i_wr && !o_full;
  assign w_do_rd = i_rd && !o_empty;
  // Masked while empty so the head reads as zero out of reset.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module uart_core #(
  parameter int DataLength      = 8,
  parameter int FifoDepth       = 8,
  parameter int OverSample      = 8,
  parameter int BaudRate        = 115200,
  parameter int SystemClockFreq = 50_000_000,
  parameter int FlowControl     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_baud_clk,
  input  logic [7:0]            i_ctrl,
  output logic [7:0]            o_status,
  input  logic [DataLength-1:0] i_tx_data,
  input  logic                  i_tx_req,
  output logic                  o_tx_rdy,
  output logic [DataLength-1:0] o_rx_data,
  input  logic                  i_rx_req,
  output logic                  o_rx_rdy,
  input  logic                  i_rx,
  output logic                  o_tx,
  input  logic                  i_cts,
  output logic                  o_rts
);
  localparam int Div   = (SystemClockFreq + (BaudRate * OverSample) / 2) / (BaudRate * OverSample);
  localparam int DivW  = $clog2(Div + 1);
  localparam int TickW = $clog2(OverSample);
  localparam int IdxW  = (DataLength > 1) ? $clog2(DataLength) : 1;
  localparam logic [DivW-1:0]  DivLast  = DivW'(Div - 1);
  localparam logic [TickW-1:0] BitLast  = TickW'(OverSample - 1);
  localparam logic [TickW-1:0] HalfLast = TickW'(OverSample / 2 - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DataLength - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic                  w_unused_ctrl;
  logic [DivW-1:0]       r_div_cnt;
  logic                  w_tick;
  logic [1:0]            r_rx_sync;
  logic [1:0]            r_cts_sync;
  logic                  w_rx_s;
  logic                  w_cts_ok;
  logic [DataLength-1:0] w_txf_head;
  logic                  w_txf_full, w_txf_empty, w_rxf_full, w_rxf_empty;
  tx_state_t             r_tx_state, w_tx_next;
  logic [TickW-1:0]      r_tx_cnt;
  logic [IdxW-1:0]       r_tx_idx;
  logic [DataLength-1:0] r_tx_shift;
  logic                  w_tx_pop, w_tx_wrap, w_tx_out, r_tx_out;
  rx_state_t             r_rx_state, w_rx_next;
  logic [TickW-1:0]      r_rx_cnt;
  logic [IdxW-1:0]       r_rx_idx;
  logic [DataLength-1:0] r_rx_shift;
  logic                  w_rx_wrap, w_rx_push, w_set_ovr, w_set_fe;
  logic                  r_rx_overrun, r_framing_err, r_rts;

  assign w_unused_ctrl = ^i_ctrl;

  assign w_tick     = (r_div_cnt == DivLast);
  assign o_baud_clk = w_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_tick) r_div_cnt <= '0;
    else                 r_div_cnt <= r_div_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_sync  <= 2'b11;
      r_cts_sync <= 2'b00;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], i_rx};
      r_cts_sync <= {r_cts_sync[0], i_cts};
    end
  end
  assign w_rx_s   = r_rx_sync[1];
  assign w_cts_ok = (FlowControl == 0) || r_cts_sync[1];

  uart_fifo #(.Width(DataLength), .Depth(FifoDepth)) u_tx_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr(i_tx_req), .i_wdata(i_tx_data), .i_rd(w_tx_pop),
    .o_rdata(w_txf_head), .o_full(w_txf_full), .o_empty(w_txf_empty));

  uart_fifo #(.Width(DataLength), .Depth(FifoDepth)) u_rx_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr(w_rx_push), .i_wdata(r_rx_shift), .i_rd(i_rx_req),
    .o_rdata(o_rx_data), .o_full(w_rxf_full), .o_empty(w_rxf_empty));

  assign o_tx_rdy = !w_txf_full;
  assign o_rx_rdy = !w_rxf_empty;

  // ---------------- transmitter ----------------
  assign w_tx_wrap = w_tick && (r_tx_cnt == BitLast);

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      TX_IDLE:  if (w_tick && !w_txf_empty && w_cts_ok) begin
                  w_tx_next = TX_START;
                  w_tx_pop  = 1'b1;
                end
      TX_START: if (w_tx_wrap) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_wrap && r_tx_idx == IdxLast) w_tx_next = TX_STOP;
      TX_STOP:  if (w_tx_wrap) w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  // The line level is registered from the next state so o_tx changes
  // exactly with the state register and never glitches on decode.
  always_comb begin
    w_tx_out = 1'b1;
    case (w_tx_next)
      TX_START: w_tx_out = 1'b0;
      TX_DATA:  w_tx_out = (r_tx_state == TX_DATA && w_tx_wrap) ? r_tx_shift[1] : r_tx_shift[0];
      default:  w_tx_out = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_out   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_out   <= w_tx_out;
    end
  end
  assign o_tx = r_tx_out;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
    end else if (w_tx_pop) begin
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= w_txf_head;
    end else if (r_tx_state != TX_IDLE && w_tick) begin
      if (w_tx_wrap) begin
        r_tx_cnt <= '0;
        if (r_tx_state == TX_DATA) begin
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_idx   <= r_tx_idx + 1'b1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  // START only waits half a bit so every later sample lands mid-bit.
  assign w_rx_wrap = w_tick && (r_rx_cnt == ((r_rx_state == RX_START) ? HalfLast : BitLast));

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_push = 1'b0;
    w_set_ovr = 1'b0;
    w_set_fe  = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_tick && !w_rx_s) w_rx_next = RX_START;
      RX_START: if (w_rx_wrap) w_rx_next = w_rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_wrap && r_rx_idx == IdxLast) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_wrap) begin
                  w_rx_next = RX_IDLE;
                  if (!w_rx_s)        w_set_fe  = 1'b1;
                  else if (w_rxf_full) w_set_ovr = 1'b1;
                  else                w_rx_push = 1'b1;
                end
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rx_state <= RX_IDLE;
    else       r_rx_state <= w_rx_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
    end else if (r_rx_state == RX_IDLE) begin
      r_rx_cnt <= '0;
      r_rx_idx <= '0;
    end else if (w_tick) begin
      if (w_rx_wrap) begin
        r_rx_cnt <= '0;
        if (r_rx_state == RX_DATA) begin
          r_rx_shift <= {w_rx_s, r_rx_shift[DataLength-1:1]};
          r_rx_idx   <= r_rx_idx + 1'b1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end
    end
  end

  // ---------------- status / flow control ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_overrun  <= 1'b0;
      r_framing_err <= 1'b0;
      r_rts         <= 1'b0;
    end else begin
      if (w_set_ovr) r_rx_overrun  <= 1'b1;
      if (w_set_fe)  r_framing_err <= 1'b1;
      r_rts <= (FlowControl != 0) ? !w_rxf_full : 1'b1;
    end
  end
  assign o_rts = r_rts;

  assign o_status = {r_rx_state != RX_IDLE, r_tx_state != TX_IDLE, r_framing_err, r_rx_overrun,
                     w_rxf_empty, w_rxf_full, w_txf_empty, w_txf_full};
endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - randomized scoreboard bench for uart_core
`timescale 1ns/1ps

module tb_uart_core;
  localparam int  DL      = 8;
  localparam int  DEPTH   = 8;
  localparam int  OS      = 8;
  localparam int  BAUD    = 115200;
  localparam int  FCLK    = 7_372_800;
  localparam int  DIV     = (FCLK + (BAUD * OS) / 2) / (BAUD * OS);
  localparam int  BIT_CYC = OS * DIV;
  localparam real CLK_HALF = 1.0e9 / FCLK / 2.0;
  localparam real BIT_NS   = 1.0e9 / BAUD;

  logic          clk = 1'b0;
  logic          rst;
  logic          baud_clk;
  logic [7:0]    ctrl;
  logic [7:0]    status;
  logic [DL-1:0] tx_data;
  logic          tx_req;
  logic          tx_rdy;
  logic [DL-1:0] rx_data;
  logic          rx_req;
  logic          rx_rdy;
  logic          rx;
  logic          tx;
  logic          cts;
  logic          rts;

  logic [DL-1:0] tx_exp[$];
  logic [DL-1:0] rx_exp[$];
  int            checks = 0;
  int            errors = 0;
  int            tx_falls = 0;
  bit            exp_ovr = 0;
  bit            exp_fe = 0;
  logic [DL-1:0] mon_byte;

  uart_core #(
    .DataLength(DL), .FifoDepth(DEPTH), .OverSample(OS),
    .BaudRate(BAUD), .SystemClockFreq(FCLK), .FlowControl(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .o_baud_clk(baud_clk), .i_ctrl(ctrl), .o_status(status),
    .i_tx_data(tx_data), .i_tx_req(tx_req), .o_tx_rdy(tx_rdy),
    .o_rx_data(rx_data), .i_rx_req(rx_req), .o_rx_rdy(rx_rdy),
    .i_rx(rx), .o_tx(tx), .i_cts(cts), .o_rts(rts)
  );

  always #(CLK_HALF) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serial TX monitor: decodes each frame mid-bit and checks it against the write order.
  initial begin : tx_mon
    forever begin
      @(negedge tx);
      if (!rst) begin
        tx_falls++;
        #(BIT_NS / 2.0);
        chk("tx_start_bit", tx, 0);
        for (int i = 0; i < DL; i++) begin
          #(BIT_NS);
          mon_byte[i] = tx;
        end
        #(BIT_NS);
        chk("tx_stop_bit", tx, 1);
        if (tx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_frame: got %0h expected none", mon_byte);
        end else begin
          chk("tx_byte", mon_byte, tx_exp.pop_front());
        end
      end
    end
  end

  // RX pop monitor: every accepted pop must present the next expected byte.
  always @(negedge clk) begin
    if (!rst && rx_req && rx_rdy) begin
      if (rx_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected_pop: got %0h expected none", rx_data);
      end else begin
        chk("rx_byte", rx_data, rx_exp.pop_front());
      end
    end
  end

  task automatic write_tx(input logic [DL-1:0] b);
    tx_data = b;
    tx_req  = 1'b1;
    @(negedge clk);
    chk("tx_rdy_on_write", tx_rdy, tx_exp.size() < DEPTH);
    if (tx_exp.size() < DEPTH) tx_exp.push_back(b);
    @(posedge clk);
    #1;
    tx_req = 1'b0;
  endtask

  task automatic send_rx(input logic [DL-1:0] b, input bit good_stop);
    if (!good_stop)                  exp_fe = 1'b1;
    else if (rx_exp.size() < DEPTH)  rx_exp.push_back(b);
    else                             exp_ovr = 1'b1;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < DL; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    if (good_stop) begin
      rx = 1'b1;
      #(BIT_NS);
    end else begin
      rx = 1'b0;
      #(BIT_NS * 0.75);
      rx = 1'b1;
      #(BIT_NS * 0.25);
    end
  endtask

  task automatic pop_n(input int n);
    int done;
    int guard;
    done = 0;
    guard = 0;
    @(posedge clk);
    #1;
    rx_req = 1'b1;
    while (done < n && guard < 4 * n + 8) begin
      @(negedge clk);
      if (rx_rdy) done++;
      guard++;
    end
    @(posedge clk);
    #1;
    rx_req = 1'b0;
    chk("rx_pop_count", done, n);
  endtask

  task automatic wait_tx_drain(input int limit);
    int c;
    c = 0;
    while (tx_exp.size() != 0 && c < limit) begin
      @(posedge clk);
      c++;
    end
    chk("tx_drain", tx_exp.size(), 0);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #(200.0 * 1000.0 * 1000.0);
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    int c;
    int falls0;
    rst = 1'b1;
    ctrl = 8'($urandom);
    rx = 1'b1;
    cts = 1'b1;
    tx_req = 1'b0;
    rx_req = 1'b0;
    tx_data = '0;

    // Reset state
    settle(3);
    chk("rst_tx", tx, 1);
    chk("rst_tx_rdy", tx_rdy, 1);
    chk("rst_rx_rdy", rx_rdy, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rts", rts, 0);
    chk("rst_baud_clk", baud_clk, 0);
    chk("rst_status", status, 8'h0A);
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle(2);
    chk("rts_after_reset", rts, 1);

    // Tick period
    c = 0;
    while (!baud_clk && c < 4 * DIV) begin
      @(negedge clk);
      c++;
    end
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!baud_clk && c < 4 * DIV);
    chk("baud_period", c, DIV);

    // TX: 4 random bytes back to back
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) write_tx(8'($urandom));
    wait_tx_drain(4 * 11 * BIT_CYC);
    settle(BIT_CYC);
    chk("tx_empty_after", status[1], 1);
    chk("tx_busy_after", status[6], 0);

    // RX: 4 random bytes at ideal baud
    for (int i = 0; i < 4; i++) send_rx(8'($urandom), 1'b1);
    settle(20);
    chk("rx_rdy_after_frames", rx_rdy, 1);
    pop_n(4);
    settle(2);
    chk("rx_rdy_drained", rx_rdy, rx_exp.size() != 0);
    chk("rx_err_bits", status[5:4], {exp_fe, exp_ovr});

    // CTS hold-off and TX FIFO full boundary
    @(posedge clk);
    #1;
    cts = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH + 2; i++) write_tx(8'($urandom));
    settle(1);
    chk("tx_full_status", status[0], 1);
    chk("tx_rdy_full", tx_rdy, 0);
    falls0 = tx_falls;
    repeat (3 * BIT_CYC) @(posedge clk);
    chk("cts_hold_falls", tx_falls, falls0);
    chk("cts_hold_line", tx, 1);
    #1;
    cts = 1'b1;
    c = 0;
    while (tx_falls == falls0 && c < DIV + 4) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("cts_start_latency", tx_falls != falls0, 1);
    wait_tx_drain(DEPTH * 11 * BIT_CYC);

    // Quarter-bit glitch is rejected
    rx = 1'b0;
    #(BIT_NS / 4.0);
    rx = 1'b1;
    settle(2 * BIT_CYC);
    chk("glitch_rx_rdy", rx_rdy, 0);
    chk("glitch_rx_busy", status[7], 0);
    chk("glitch_fe", status[5], exp_fe);

    // Framing error
    send_rx(8'($urandom), 1'b0);
    settle(BIT_CYC);
    chk("fe_sticky", status[5], exp_fe);
    chk("fe_no_push", rx_rdy, rx_exp.size() != 0);

    // Overrun: 9 frames without popping
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_rx(8'($urandom), 1'b1);
      if (i == DEPTH - 1) begin
        settle(4);
        chk("rts_when_full", rts, rx_exp.size() < DEPTH);
        chk("rx_full_status", status[2], rx_exp.size() == DEPTH);
        chk("ovr_before_9th", status[4], exp_ovr);
      end
    end
    settle(4);
    chk("ovr_sticky", status[4], exp_ovr);
    pop_n(DEPTH);
    settle(3);
    chk("rts_after_pops", rts, rx_exp.size() < DEPTH);
    chk("rx_rdy_after_pops", rx_rdy, rx_exp.size() != 0);
    chk("ovr_still_set", status[4], exp_ovr);

    chk("tx_queue_left", tx_exp.size(), 0);
    chk("rx_queue_left", rx_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
